gemm_apb_ctrl: RTL and testbench

GEMM_APB_CTRL -- requirements
Module: gemm_apb_ctrl

---
 rtl/gemm_apb_ctrl_if.sv | 33 +++
 rtl/gemm_apb_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_gemm_apb_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_apb_ctrl_if.sv
// ---------------------------------------------------------------------------
// gemm_apb_ctrl_if
// APB3/APB4 completer-side bus bundle for the GEMM controller.
//   paddr/psel/penable/pwrite/pwdata/pstrb/pprot : requester -> completer
//   prdata/pready/pslverr                         : completer -> requester
// The 'slave' modport is what gemm_apb_ctrl consumes; 'master' is for the
// requester (bus fabric or testbench).
// ---------------------------------------------------------------------------
interface gemm_apb_ctrl_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [3:0]                pstrb;
    logic [2:0]                pprot;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/gemm_apb_ctrl.sv
// ---------------------------------------------------------------------------
// gemm_apb_ctrl
// APB-programmable launch/monitor controller for a GEMM datapath.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-low
//   s_apb      : APB completer (gemm_apb_ctrl_if.slave), zero wait states
//   dp_start   : one-cycle launch pulse to the datapath
//   dp_m/n/k   : dimensions latched at launch, stable for the whole job
//   dp_done    : one-cycle completion pulse from the datapath
//   out_led    : {irq, err, done, busy}
//
// Register map (byte addresses, bits [1:0] ignored, anything >= 0x10 is
// unmapped and answers pslverr=1 with no side effect)
//   0x0 CTRL   : [0] START (write-1 pulse, reads 0), [1] IRQ_EN
//   0x4 STATUS : [0] BUSY (ro), [1] DONE, [2] ERR, [3] TIMEOUT (sticky, W1C)
//   0x8 DIM    : M [DIM_WIDTH-1:0], N next field, K next field
//   0xC CYCLES : RUN cycles of the last job (ro, writes silently dropped)
// ---------------------------------------------------------------------------
module gemm_apb_ctrl #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int DIM_WIDTH      = 8,
    parameter int TIMEOUT        = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    gemm_apb_ctrl_if.slave       s_apb,
    output logic                 dp_start,
    output logic [DIM_WIDTH-1:0] dp_m,
    output logic [DIM_WIDTH-1:0] dp_n,
    output logic [DIM_WIDTH-1:0] dp_k,
    input  logic                 dp_done,
    output logic [3:0]           out_led
);

    localparam int DW = DIM_WIDTH;
    localparam logic [APB_DATA_WIDTH-1:0] TMO_LIMIT = APB_DATA_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                    state;
    logic                      irq_en;
    logic                      st_done;
    logic                      st_err;
    logic                      st_tmo;
    logic [DW-1:0]             dim_m;
    logic [DW-1:0]             dim_n;
    logic [DW-1:0]             dim_k;
    logic [APB_DATA_WIDTH-1:0] cycles;
    logic [APB_DATA_WIDTH-1:0] cycles_inc;

    // ---------------------------------------------------------------------
    // APB decode
    // ---------------------------------------------------------------------
    logic access, wr, rd, in_window;
    logic sel_ctrl, sel_status, sel_dim, sel_cycles;
    logic busy, dims_ok, start_req, start_go, start_bad, run_tmo, irq;

    assign access     = s_apb.psel & s_apb.penable;
    assign wr         = access & s_apb.pwrite;
    assign rd         = access & ~s_apb.pwrite;
    assign in_window  = (s_apb.paddr[APB_ADDR_WIDTH-1:4] == '0);
    assign sel_ctrl   = in_window & (s_apb.paddr[3:2] == 2'd0);
    assign sel_status = in_window & (s_apb.paddr[3:2] == 2'd1);
    assign sel_dim    = in_window & (s_apb.paddr[3:2] == 2'd2);
    assign sel_cycles = in_window & (s_apb.paddr[3:2] == 2'd3);

    assign busy      = (state != IDLE);
    assign dims_ok   = (|dim_m) & (|dim_n) & (|dim_k);
    assign start_req = wr & sel_ctrl & s_apb.pwdata[0];
    assign start_go  = start_req & ~busy & dims_ok;
    assign start_bad = start_req & ~busy & ~dims_ok;

    // Saturating RUN counter; the timeout fires on the cycle the count
    // would reach the limit, so a job that times out reports CYCLES=TIMEOUT.
    assign cycles_inc = (&cycles) ? cycles : cycles + APB_DATA_WIDTH'(1);
    assign run_tmo    = (cycles_inc >= TMO_LIMIT);

    assign irq     = irq_en & (st_done | st_err);
    assign out_led = {irq, st_err, st_done, busy};

    assign s_apb.pready = 1'b1;

    // Strobes, protection and the undecoded address/data bits carry no
    // meaning here; fold them into one sink so they are visibly consumed.
    logic unused_apb;
    assign unused_apb = ^{s_apb.pstrb, s_apb.pprot, s_apb.paddr[1:0], s_apb.pwdata};

    // ---------------------------------------------------------------------
    // Read data / error response (access phase only). Gated by reset so the
    // bus reads quiet while the block is held in reset.
    // ---------------------------------------------------------------------
    always_comb begin
        s_apb.prdata  = '0;
        s_apb.pslverr = 1'b0;
        if (reset && access) begin
            if (!in_window) begin
                s_apb.pslverr = 1'b1;
            end else if (rd) begin
                case (s_apb.paddr[3:2])
                    2'd0:    s_apb.prdata = APB_DATA_WIDTH'({irq_en, 1'b0});
                    2'd1:    s_apb.prdata = APB_DATA_WIDTH'({st_tmo, st_err, st_done, busy});
                    2'd2:    s_apb.prdata = APB_DATA_WIDTH'({dim_k, dim_n, dim_m});
                    default: s_apb.prdata = cycles;
                endcase
            end else begin
                // Job-shaping writes are refused while a job is in flight;
                // an IRQ_EN-only CTRL write is still fine.
                s_apb.pslverr = busy & ((sel_ctrl & s_apb.pwdata[0]) | sel_dim);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers and job FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            irq_en   <= 1'b0;
            st_done  <= 1'b0;
            st_err   <= 1'b0;
            st_tmo   <= 1'b0;
            dim_m    <= '0;
            dim_n    <= '0;
            dim_k    <= '0;
            cycles   <= '0;
            dp_start <= 1'b0;
            dp_m     <= '0;
            dp_n     <= '0;
            dp_k     <= '0;
        end else begin
            dp_start <= 1'b0;

            if (wr && sel_ctrl) irq_en <= s_apb.pwdata[1];

            if (wr && sel_dim && !busy) begin
                dim_m <= s_apb.pwdata[DW-1:0];
                dim_n <= s_apb.pwdata[2*DW-1:DW];
                dim_k <= s_apb.pwdata[3*DW-1:2*DW];
            end

            // W1C first; hardware sets below override it on the same edge.
            if (wr && sel_status) begin
                if (s_apb.pwdata[1]) st_done <= 1'b0;
                if (s_apb.pwdata[2]) st_err  <= 1'b0;
                if (s_apb.pwdata[3]) st_tmo  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_go) begin
                        // Dimensions are captured on entry to LAUNCH so they
                        // are already valid while dp_start is high.
                        state    <= LAUNCH;
                        dp_start <= 1'b1;
                        dp_m     <= dim_m;
                        dp_n     <= dim_n;
                        dp_k     <= dim_k;
                        cycles   <= '0;
                        st_done  <= 1'b0;
                        st_err   <= 1'b0;
                        st_tmo   <= 1'b0;
                    end else if (start_bad) begin
                        st_err <= 1'b1;
                    end
                end
                LAUNCH: state <= RUN;
                RUN: begin
                    cycles <= cycles_inc;
                    // A completion on the timeout cycle counts as success.
                    if (dp_done) begin
                        state <= DRAIN;
                    end else if (run_tmo) begin
                        state  <= DRAIN;
                        st_err <= 1'b1;
                        st_tmo <= 1'b1;
                    end
                end
                DRAIN: begin
                    st_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gemm_apb_ctrl
// Register-map vector table, hand-written multi-cycle sequences, then random
// jobs checked against a job-level model of the controller.
// ---------------------------------------------------------------------------
module tb_gemm_apb_ctrl;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dp_start;
    logic       dp_done;
    logic [7:0] dp_m, dp_n, dp_k;
    logic [3:0] out_led;

    always #5 clk = ~clk;

    gemm_apb_ctrl_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) apb ();

    gemm_apb_ctrl #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .DIM_WIDTH(8),
        .TIMEOUT(TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_apb   (apb),
        .dp_start(dp_start),
        .dp_m    (dp_m),
        .dp_n    (dp_n),
        .dp_k    (dp_k),
        .dp_done (dp_done),
        .out_led (out_led)
    );

    int errors = 0;
    int checks = 0;

    // Datapath stand-in: pulses dp_done done_delay cycles after dp_start
    // (0 = never). Also counts launches and measures dp_start->DONE latency.
    int  starts = 0, cyc = 0, start_cyc = 0, lat = -1, done_delay = 0, cd = 0;
    bit  wait_done = 0, pulse_b = 0, stray_done = 0;
    assign dp_done = pulse_b | stray_done;

    always @(negedge clk) begin
        cyc++;
        pulse_b = 0;
        if (dp_start) begin
            starts++;
            start_cyc = cyc;
            wait_done = 1;
            lat = -1;
            cd = done_delay;
        end else begin
            if (wait_done && out_led[1]) begin
                lat = cyc - start_cyc;
                wait_done = 0;
            end
            if (cd > 0) begin
                cd--;
                pulse_b = (cd == 0);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_xfer(input bit w, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rdata, output logic err);
        @(negedge clk);
        apb.psel = 1; apb.penable = 0; apb.pwrite = w; apb.paddr = addr; apb.pwdata = data;
        @(negedge clk);
        apb.penable = 1;
        #1;
        rdata = apb.prdata;
        err   = apb.pslverr;
        @(posedge clk);
        #1;
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err,
                      input string name);
        logic [31:0] d;
        logic e;
        apb_xfer(1, addr, data, d, e);
        chk({name, " pslverr"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err,
                      input string name);
        logic [31:0] d;
        logic e;
        apb_xfer(0, addr, 32'h0, d, e);
        chk({name, " prdata"}, d, exp);
        chk({name, " pslverr"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (out_led[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, " busy cleared"}, {31'b0, out_led[0]}, 32'h0);
    endtask

    typedef struct {
        string       name;
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input string name, input bit w, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                    input logic exp_err);
        vec_t v;
        v.name = name; v.w = w; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [31:0] d;
        logic e;
        bit seen;
        // job-level model state
        bit m_done, m_err, m_tmo, m_ie;
        logic [31:0] m_cyc, m_dim;
        logic [23:0] m_dp;

        apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = 0;
        apb.pwdata = 0; apb.pstrb = 4'hF; apb.pprot = 3'b0;

        // ---------------- reset state ----------------
        #2 reset = 0;
        repeat (3) @(negedge clk);
        chk("reset dp_start", {31'b0, dp_start}, 0);
        chk("reset dims", {8'h0, dp_k, dp_n, dp_m}, 0);
        chk("reset out_led", {28'b0, out_led}, 0);
        chk("reset prdata", apb.prdata, 0);
        chk("reset pslverr", {31'b0, apb.pslverr}, 0);
        reset = 1;

        // ---------------- register map table ----------------
        add_vec("rd ctrl",       0, 32'h0,        0,            0,          0);
        add_vec("rd status",     0, 32'h4,        0,            0,          0);
        add_vec("rd dim",        0, 32'h8,        0,            0,          0);
        add_vec("rd cycles",     0, 32'hC,        0,            0,          0);
        add_vec("wr dim",        1, 32'h8,        32'hFF030204, 0,          0);
        add_vec("rd dim back",   0, 32'h8,        0,            32'h030204, 0);
        add_vec("rd dim alias",  0, 32'hB,        0,            32'h030204, 0);
        add_vec("wr irq_en",     1, 32'h0,        32'h2,        0,          0);
        add_vec("rd irq_en",     0, 32'h0,        0,            32'h2,      0);
        add_vec("clr irq_en",    1, 32'h0,        32'h0,        0,          0);
        add_vec("rd ctrl 0",     0, 32'h0,        0,            0,          0);
        add_vec("wr cycles",     1, 32'hC,        32'hFFFF,     0,          0);
        add_vec("rd cycles 0",   0, 32'hC,        0,            0,          0);
        add_vec("rd unmapped",   0, 32'h10,       0,            0,          1);
        add_vec("wr unmapped",   1, 32'h10,       32'h1,        0,          1);
        add_vec("no alias start",0, 32'h4,        0,            0,          0);
        add_vec("wr status ro",  1, 32'h4,        32'hF,        0,          0);
        add_vec("rd status 0",   0, 32'h4,        0,            0,          0);
        add_vec("rd high addr",  0, 32'hFFFFFFF8, 0,            0,          1);
        foreach (vecs[i]) begin
            apb_xfer(vecs[i].w, vecs[i].addr, vecs[i].wdata, d, e);
            chk({vecs[i].name, " prdata"}, d, vecs[i].exp_rdata);
            chk({vecs[i].name, " pslverr"}, {31'b0, e}, {31'b0, vecs[i].exp_err});
        end

        // ---------------- normal job ----------------
        done_delay = 10; s0 = starts;
        wr(32'h0, 32'h1, 0, "start1");
        wait_idle("job1");
        chk("job1 dims", {8'h0, dp_k, dp_n, dp_m}, 32'h030204);
        chk("job1 launches", starts - s0, 1);
        rd(32'h4, 32'h2, 0, "job1 status");
        rd(32'hC, 32'd10, 0, "job1 cycles");
        chk("job1 out_led", {28'b0, out_led}, 32'b0010);
        chk("job1 latency", lat, 12);

        // ---------------- zero-dimension start ----------------
        wr(32'h4, 32'hE, 0, "clr1");
        rd(32'h4, 32'h0, 0, "clr1 status");
        wr(32'h8, 32'h000204, 0, "dim zero k");
        s0 = starts;
        wr(32'h0, 32'h1, 0, "bad start");
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen |= out_led[0];
        end
        chk("bad start busy", {31'b0, seen}, 0);
        rd(32'h4, 32'h4, 0, "bad start status");
        chk("bad start launches", starts - s0, 0);

        // ---------------- busy rejection + timeout ----------------
        wr(32'h4, 32'hE, 0, "clr2");
        wr(32'h8, 32'h030204, 0, "dim2");
        done_delay = 0; s0 = starts;
        wr(32'h0, 32'h1, 0, "start3");
        wr(32'h0, 32'h1, 1, "start while busy");
        wr(32'h8, 32'h050505, 1, "dim while busy");
        rd(32'h8, 32'h030204, 0, "dim kept");
        wr(32'h0, 32'h2, 0, "irq_en while busy");
        chk("still busy", {31'b0, out_led[0]}, 1);
        wait_idle("tmo");
        rd(32'h4, 32'hE, 0, "tmo status");
        rd(32'hC, TMO, 0, "tmo cycles");
        chk("tmo out_led", {28'b0, out_led}, 32'hE);
        chk("tmo launches", starts - s0, 1);
        wr(32'h4, 32'hE, 0, "tmo w1c");
        rd(32'h4, 32'h0, 0, "tmo cleared");
        chk("irq cleared", {28'b0, out_led}, 0);

        // ---------------- dp_done on the timeout cycle ----------------
        done_delay = TMO;
        wr(32'h0, 32'h3, 0, "start4");
        wait_idle("race");
        rd(32'h4, 32'h2, 0, "race status");
        rd(32'hC, TMO, 0, "race cycles");
        chk("race out_led", {28'b0, out_led}, 32'b1010);
        rd(32'h10, 32'h0, 1, "race unmapped");

        // ---------------- W1C DONE on the DRAIN edge: set wins ----------------
        wr(32'h4, 32'hE, 0, "clr5");
        done_delay = 3;
        wr(32'h0, 32'h1, 0, "start5");
        @(negedge clk);
        chk("start5 pulse", {31'b0, dp_start}, 1);
        repeat (3) @(negedge clk);
        apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = 32'h4; apb.pwdata = 32'h2;
        @(negedge clk);
        chk("drain busy", {31'b0, out_led[0]}, 1);
        chk("drain done not yet", {31'b0, out_led[1]}, 0);
        apb.penable = 1;
        @(posedge clk);
        #1;
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
        rd(32'h4, 32'h2, 0, "set wins status");
        rd(32'hC, 32'd3, 0, "set wins cycles");

        // ---------------- stray dp_done in IDLE and LAUNCH ----------------
        wr(32'h4, 32'hE, 0, "clr6");
        @(negedge clk); stray_done = 1;
        @(negedge clk); stray_done = 0;
        rd(32'h4, 32'h0, 0, "idle stray status");
        done_delay = 5;
        wr(32'h0, 32'h1, 0, "start6");
        @(negedge clk); stray_done = 1;
        @(negedge clk); stray_done = 0;
        wait_idle("stray");
        rd(32'hC, 32'd5, 0, "stray cycles");
        rd(32'h4, 32'h2, 0, "stray status");

        // ---------------- reset mid-RUN ----------------
        done_delay = 0;
        wr(32'h0, 32'h1, 0, "start7");
        @(negedge clk);
        repeat (5) @(negedge clk);
        #1 reset = 0;
        #1;
        chk("abort dp_start", {31'b0, dp_start}, 0);
        chk("abort dims", {8'h0, dp_k, dp_n, dp_m}, 0);
        chk("abort out_led", {28'b0, out_led}, 0);
        @(negedge clk);
        reset = 1;
        rd(32'h4, 32'h0, 0, "abort status");
        rd(32'h8, 32'h0, 0, "abort dim");
        wr(32'h8, 32'h010101, 0, "dim8");
        done_delay = 7;
        wr(32'h0, 32'h1, 0, "start8");
        wait_idle("after abort");
        rd(32'h4, 32'h2, 0, "after abort status");
        rd(32'hC, 32'd7, 0, "after abort cycles");
        chk("after abort dims", {8'h0, dp_k, dp_n, dp_m}, 32'h010101);

        // ---------------- random jobs vs job-level model ----------------
        reset = 0;
        @(negedge clk);
        reset = 1;
        m_done = 0; m_err = 0; m_tmo = 0; m_ie = 0; m_cyc = 0; m_dim = 0; m_dp = 0;
        for (int it = 0; it < 30; it++) begin
            logic [7:0] m, n, k;
            logic [3:0] mask;
            int dly;
            bit ie, ok, hit;
            m   = ($urandom_range(0, 5) == 0) ? 8'h0 : 8'($urandom_range(1, 255));
            n   = ($urandom_range(0, 5) == 0) ? 8'h0 : 8'($urandom_range(1, 255));
            k   = ($urandom_range(0, 5) == 0) ? 8'h0 : 8'($urandom_range(1, 255));
            dly = $urandom_range(0, 20);
            ie  = 1'($urandom_range(0, 1));
            done_delay = dly;
            wr(32'h8, {8'h0, k, n, m}, 0, "rnd dim");
            m_dim = {8'h0, k, n, m};
            s0 = starts;
            wr(32'h0, {30'b0, ie, 1'b1}, 0, "rnd start");
            m_ie = ie;
            wait_idle("rnd");
            ok = (m != 0) && (n != 0) && (k != 0);
            if (ok) begin
                hit    = (dly >= 1) && (dly <= TMO);
                m_cyc  = hit ? dly : TMO;
                m_done = 1;
                m_err  = !hit;
                m_tmo  = !hit;
                m_dp   = {k, n, m};
            end else begin
                m_err = 1;
            end
            chk("rnd launches", starts - s0, ok ? 1 : 0);
            rd(32'h4, {28'b0, m_tmo, m_err, m_done, 1'b0}, 0, "rnd status");
            rd(32'hC, m_cyc, 0, "rnd cycles");
            rd(32'h8, m_dim, 0, "rnd dimreg");
            rd(32'h0, {30'b0, m_ie, 1'b0}, 0, "rnd ctrl");
            chk("rnd dp dims", {8'h0, dp_k, dp_n, dp_m}, {8'h0, m_dp});
            chk("rnd out_led", {28'b0, out_led},
                {28'b0, m_ie & (m_done | m_err), m_err, m_done, 1'b0});
            if (ok) chk("rnd latency", lat, m_cyc + 2);
            mask = 4'($urandom_range(0, 15));
            wr(32'h4, {28'b0, mask}, 0, "rnd w1c");
            if (mask[1]) m_done = 0;
            if (mask[2]) m_err = 0;
            if (mask[3]) m_tmo = 0;
        end
        rd(32'h4, {28'b0, m_tmo, m_err, m_done, 1'b0}, 0, "final status");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
